// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: cascadable DIGITS-decade synchronous BCD counter with 74160-style controls
//   CP  clock (rising edge)         Rd  async clear, active-low
//   LD  sync load, active-low       EP/ET  parallel/trickle count enables (ET also gates C)
//   UD  1=up 0=down                 D   BCD load value, LIM  wrap limit (modulus LIM+1)
//   Q   registered count            C   combinational terminal count
//   ERR sticky illegal-load flag
//   Define BCD_CHAIN_DOWN_EN to honour UD; otherwise UD is ignored and the counter counts up only.
module bcd_counter_chain #(
    parameter int DIGITS = 2
) (
    input  logic                CP,
    input  logic                Rd,
    input  logic                LD,
    input  logic                EP,
    input  logic                ET,
    input  logic                UD,
    input  logic [4*DIGITS-1:0] D,
    input  logic [4*DIGITS-1:0] LIM,
    output logic [4*DIGITS-1:0] Q,
    output logic                C,
    output logic                ERR
);
    localparam int W = 4*DIGITS;
    logic [W-1:0] q_q, q_d, lim_c, inc, ld_val;
    logic         err_q, err_d, bad, carry, at_lim, at_zero, step;
`ifdef BCD_CHAIN_DOWN_EN
    logic [W-1:0] dec;
    logic         borrow;
`else
    logic         unused_ud;
    assign unused_ud = UD;
`endif
    always_comb begin
        lim_c  = '0;
        inc    = '0;
        ld_val = '0;
        bad    = 1'b0;
        carry  = 1'b1;
`ifdef BCD_CHAIN_DOWN_EN
        dec    = '0;
        borrow = 1'b1;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            // out-of-range limit digits saturate to 9, illegal load digits load as 0
            lim_c[4*i+:4]  = (LIM[4*i+:4] > 4'd9) ? 4'd9 : LIM[4*i+:4];
            ld_val[4*i+:4] = (D[4*i+:4] > 4'd9) ? 4'd0 : D[4*i+:4];
            bad            = bad | (D[4*i+:4] > 4'd9);
            inc[4*i+:4]    = carry ? ((q_q[4*i+:4] == 4'd9) ? 4'd0 : q_q[4*i+:4] + 4'd1) : q_q[4*i+:4];
            carry          = carry & (q_q[4*i+:4] == 4'd9);
`ifdef BCD_CHAIN_DOWN_EN
            dec[4*i+:4]    = borrow ? ((q_q[4*i+:4] == 4'd0) ? 4'd9 : q_q[4*i+:4] - 4'd1) : q_q[4*i+:4];
            borrow         = borrow & (q_q[4*i+:4] == 4'd0);
`endif
        end
    end
    assign at_lim  = (q_q == lim_c);
    assign at_zero = (q_q == '0);
    assign step    = LD & EP & ET;
    // a Q above LIM never matches at_lim, so it rolls on until the all-9s wrap
    always_comb begin
        q_d = q_q;
        if (!LD)
            q_d = ld_val;
        else if (step)
`ifdef BCD_CHAIN_DOWN_EN
            q_d = UD ? (at_lim ? '0 : inc) : (at_zero ? lim_c : dec);
`else
            q_d = at_lim ? '0 : inc;
`endif
    end
    assign err_d = err_q | (!LD & bad);
    always_ff @(posedge CP or negedge Rd) begin
        if (!Rd) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end
    assign Q   = q_q;
    assign ERR = err_q;
`ifdef BCD_CHAIN_DOWN_EN
    assign C = ET & (UD ? at_lim : at_zero);
`else
    assign C = ET & at_lim;
`endif
endmodule

// File: doc/bcd_counter_chain.md
# bcd_counter_chain

Parametrised, cascadable synchronous BCD counter, generalising the single-digit 74160 decade stage to DIGITS decades. It adds a programmable wrap limit, optional down-counting and load-error flagging. The control semantics (Rd/LD/EP/ET/C) match the 74160 stage, so it drops into the same counter/timer datapaths in place of hand-chained 74160 instances.

## Interface
- DIGITS, default 2: number of BCD decades, legal range 1..8; all data buses are 4*DIGITS bits, digit 0 in bits [3:0].
- CP  in  1  clock; all state updates on the rising edge.
- Rd  in  1  asynchronous, active-low reset (clear).
- LD  in  1  synchronous parallel load, active-low.
- EP  in  1  count enable, parallel.
- ET  in  1  count enable, trickle; also gates C.
- UD  in  1  direction: 1 = up, 0 = down. Only active with the down-count feature (see Configuration).
- D  in  4*DIGITS  BCD load value.
- LIM  in  4*DIGITS  wrap limit, giving modulus LIM+1; must be quasi-static while counting.
- Q  out  4*DIGITS  registered count.
- C  out  1  terminal-count / carry output, combinational.
- ERR  out  1  sticky flag for an illegal load value, registered.

## Operation
- Priority: Rd, then LD, then count, then hold.
- Rd=0: Q=0 and ERR=0 immediately, independent of CP.
- LD=0 at an edge: each digit loads from D regardless of EP/ET.
  - A D digit greater than 9 loads as 0 and sets ERR=1.
  - ERR stays set until Rd.
- Count step occurs when LD=1 and EP=1 and ET=1.
- Up count:
  - If Q==LIM, Q becomes 0.
  - Otherwise Q becomes the BCD increment of Q. A digit at 9 goes to 0 and carries into the next digit.
  - From all-9s, Q wraps to 0.
- Down count:
  - If Q==0, Q becomes LIM.
  - Otherwise Q becomes the BCD decrement of Q. A digit at 0 goes to 9 and borrows from the next digit.
- LIM digits greater than 9 are treated as 9. LIM=0 holds Q at 0 while counting, with C=ET.
- Q>LIM (reachable only after a load):
  - Up count increments normally until it wraps from all-9s to 0.
  - Down count decrements normally down to LIM, and Q stays in range from then on.
- Cascading: C of stage n drives ET of stage n+1. EP and CP are shared.
- C = ET & (UD ? Q==LIM : Q==0). C does not depend on EP, LD or CP.

## Timing
- Q and ERR are registered: load and count results appear one CP edge after the request. There is no other latency.
- C is combinational from Q, ET, UD and LIM, and is valid within the same cycle.
- Reset values: Q=0, ERR=0. C=0 if ET=0 or (up and LIM≠0). C=ET if down, or if LIM=0.
- Rd assertion is asynchronous. After deassertion, the first action happens at the next rising CP.
- Rd asserted mid-count aborts any step: no partial digit update is visible.
- LD=0 with EP=ET=1 at the same edge: the load wins and no step is taken.
- A UD change takes effect at the next edge. C follows UD immediately.

## Configuration
- Macro BCD_CHAIN_DOWN_EN.
  - Defined: UD is honoured as described above.
  - Undefined:
    - UD is ignored and the block counts up only.
    - C = ET & (Q==LIM).
    - The down-count and borrow logic is not synthesised.
    - The UD port still exists, so instantiations do not change.

## Test plan
- DIGITS=2, LIM=59, up, EP=ET=1 from Q=0:
  - Q steps 00..59 then 00.
  - C=1 only while Q=59.
  - 60 edges make one full period.
- Load D=0x1C (digit 0 illegal) with LD=0:
  - Q=0x10 and ERR=1.
  - ERR stays 1 through 100 count edges, and clears only when Rd=0.
- Q=0x39 up with LIM=99: next edge gives Q=0x40, showing the digit carry. Set EP=0: Q holds and C still tracks ET.
- BCD_CHAIN_DOWN_EN, UD=0, LIM=23:
  - From Q=0x10: 0x09, then 0x08, and so on down to 0x00, then 0x23.
  - C=1 while Q=0.
  - Repeat without the macro: the same stimulus counts up.
- Assert Rd asynchronously mid-cycle at Q=0x47: Q=0x00 before the next edge. LD=0 together with EP=ET=1: the loaded value wins.
- Two instances with DIGITS=1 cascaded through C into ET, compared against one DIGITS=2 instance: identical Q sequences over 200 cycles.
